// File: rtl/maxpool_layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_layer_pkg
//  Description : Shared numeric constants for the layer stages (word width,
//                channel count, position counts) plus derived vector widths,
//                the counter-derived state codes and a slice-offset helper.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef DATA_LEN_DEF
`define DATA_LEN_DEF 16
`endif

package maxpool_layer_pkg;

   // Word and frame geometry
   localparam int DATA_LEN = `DATA_LEN_DEF;
   localparam int CH       = 12;
   localparam int POS_IN   = 32;
   localparam int POS_OUT  = POS_IN / 2;

   // Counter widths: indices run 0..POS_OUT inclusive, tags 0..POS_OUT-1
   localparam int IDX_W    = $clog2(POS_OUT + 1);
   localparam int TAG_W    = $clog2(POS_OUT);

   // Packed vector widths
   localparam int ROW_W    = CH * DATA_LEN;
   localparam int D_W      = POS_IN * ROW_W;
   localparam int Q_W      = POS_OUT * ROW_W;
   localparam int D_OFF_W  = $clog2(D_W);
   localparam int Q_OFF_W  = $clog2(Q_W);

   // States, derived from load/valid and the counters
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Bit offset of the first word of input pair idx (position 2*idx)
   function automatic logic [D_OFF_W-1:0] pair_base(input logic [TAG_W-1:0] idx);
      return D_OFF_W'(idx) * D_OFF_W'(2 * ROW_W);
   endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_layer_max2_signed.sv
`default_nettype none
// ============================================================================
//  Module      : max2_signed
//  Description : Combinational signed maximum of two two's-complement words.
//                Full-width compare, no growth; ties return the shared value.
//  Revision    : 1.0  initial release
// ============================================================================

module max2_signed #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_max
);

   // Pick the larger operand under signed interpretation
   always_comb begin
      o_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
   end

endmodule

`default_nettype wire

// File: rtl/maxpool_layer.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_layer
//  Description : 1-D max pooling, window 2 / stride 2, per channel. One
//                position pair (CH compares) per cycle through a 2-stage
//                pipeline: stage 1 selects a pair, stage 2 compares and
//                writes one output position. Level-sensitive load/valid.
//  Revision    : 1.0  initial release
// ============================================================================

module maxpool_layer
   import maxpool_layer_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [D_W-1:0] d,
   output logic           valid,
   output logic [Q_W-1:0] q
);

   localparam logic [IDX_W-1:0] C_POS_OUT = IDX_W'(POS_OUT);

   // Counters and flags
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic             s1_v_q,   s1_v_d;
   logic [TAG_W-1:0] tag_q,    tag_d;
   logic             valid_q,  valid_d;

   // Stage-1 operand registers: even (a) and odd (b) position of the pair
   logic [ROW_W-1:0] a_q, a_d;
   logic [ROW_W-1:0] b_q, b_d;

   // Result storage
   logic [Q_W-1:0]   q_q, q_d;

   // Combinational helpers
   logic [1:0]         w_state;
   logic [D_OFF_W-1:0] w_base;
   logic [Q_OFF_W-1:0] w_q_off;
   logic [ROW_W-1:0]   w_max_row;

   // Stage 2 compare lanes, one signed max per channel
   for (genvar g = 0; g < CH; g++) begin : g_ch
      max2_signed #(
         .DW (DATA_LEN)
      ) u_max2 (
         .i_a   (a_q[g*DATA_LEN +: DATA_LEN]),
         .i_b   (b_q[g*DATA_LEN +: DATA_LEN]),
         .o_max (w_max_row[g*DATA_LEN +: DATA_LEN])
      );
   end

   // Derive the operating state from load, valid and the read counter
   always_comb begin
      if (!load) begin
         w_state = ST_IDLE;
      end else if (valid_q) begin
         w_state = ST_DONE;
      end else if (rd_idx_q < C_POS_OUT) begin
         w_state = ST_FILL;
      end else begin
         w_state = ST_DRAIN;
      end
   end

   // Slice offsets: input pair at rd_idx, output row at the stage-1 tag
   always_comb begin
      w_base  = pair_base(rd_idx_q[TAG_W-1:0]);
      w_q_off = Q_OFF_W'(tag_q) * Q_OFF_W'(ROW_W);
   end

   // Next-state logic for both pipeline stages and the completion flag
   always_comb begin
      rd_idx_d = rd_idx_q;
      wr_idx_d = wr_idx_q;
      s1_v_d   = s1_v_q;
      tag_d    = tag_q;
      valid_d  = valid_q;
      a_d      = a_q;
      b_d      = b_q;
      q_d      = q_q;

      case (w_state)
         ST_IDLE: begin
            // Clear for the next frame; q is kept until overwritten
            valid_d  = 1'b0;
            rd_idx_d = '0;
            wr_idx_d = '0;
            s1_v_d   = 1'b0;
         end

         ST_FILL: begin
            // Stage 1: capture positions 2*rd_idx and 2*rd_idx+1
            a_d      = d[w_base +: ROW_W];
            b_d      = d[w_base + D_OFF_W'(ROW_W) +: ROW_W];
            s1_v_d   = 1'b1;
            tag_d    = rd_idx_q[TAG_W-1:0];
            rd_idx_d = rd_idx_q + 1'b1;
            // Stage 2: write the previously selected pair
            if (s1_v_q && (wr_idx_q < C_POS_OUT)) begin
               q_d[w_q_off +: ROW_W] = w_max_row;
               wr_idx_d              = wr_idx_q + 1'b1;
            end
         end

         ST_DRAIN: begin
            // Nothing left to select; finish the last write, then flag done
            s1_v_d = 1'b0;
            if (s1_v_q && (wr_idx_q < C_POS_OUT)) begin
               q_d[w_q_off +: ROW_W] = w_max_row;
               wr_idx_d              = wr_idx_q + 1'b1;
            end
            if (wr_idx_q == C_POS_OUT) begin
               valid_d = 1'b1;
            end
         end

         default: begin
            // Done: everything holds, q frozen while load stays high
            s1_v_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         s1_v_q   <= 1'b0;
         tag_q    <= '0;
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         q_q      <= '0;
      end else begin
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         s1_v_q   <= s1_v_d;
         tag_q    <= tag_d;
         valid_q  <= valid_d;
         a_q      <= a_d;
         b_q      <= b_d;
         q_q      <= q_d;
      end
   end

   assign valid = valid_q;
   assign q     = q_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_layer
//  Description : Directed and randomized checks of maxpool_layer against a
//                behavioural pooling model (and an ELU model upstream for the
//                chained frames).
//  Revision    : 1.0  initial release
// ============================================================================

module tb_maxpool_layer;
   import maxpool_layer_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           load;
   logic [D_W-1:0] d;
   logic           valid;
   logic [Q_W-1:0] q;
   logic           elu_valid;

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [DATA_LEN-1:0] din  [POS_IN][CH];
   logic signed [DATA_LEN-1:0] expq [POS_OUT][CH];
   logic signed [DATA_LEN-1:0] oldq [POS_OUT][CH];

   maxpool_layer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .d     (d),
      .valid (valid),
      .q     (q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pack the word array into the flat input bus
   task automatic pack_d();
      for (int p = 0; p < POS_IN; p++)
         for (int c = 0; c < CH; c++)
            d[(p*CH+c)*DATA_LEN +: DATA_LEN] = din[p][c];
   endtask

   // Reference: each output word is the larger of its two inputs
   task automatic model();
      for (int k = 0; k < POS_OUT; k++)
         for (int c = 0; c < CH; c++) begin
            if (din[2*k][c] >= din[2*k+1][c]) expq[k][c] = din[2*k][c];
            else                              expq[k][c] = din[2*k+1][c];
         end
   endtask

   function automatic logic [DATA_LEN-1:0] qw(input int k, input int c);
      return q[(k*CH+c)*DATA_LEN +: DATA_LEN];
   endfunction

   function automatic logic [ROW_W-1:0] qrow(input int k);
      return q[k*ROW_W +: ROW_W];
   endfunction

   function automatic logic [ROW_W-1:0] exprow(input int k);
      logic [ROW_W-1:0] r;
      for (int c = 0; c < CH; c++) r[c*DATA_LEN +: DATA_LEN] = expq[k][c];
      return r;
   endfunction

   function automatic logic [ROW_W-1:0] oldrow(input int k);
      logic [ROW_W-1:0] r;
      for (int c = 0; c < CH; c++) r[c*DATA_LEN +: DATA_LEN] = oldq[k][c];
      return r;
   endfunction

   // ELU, Q8.8: x for x >= 0, exp(x) - 1 otherwise
   function automatic logic [DATA_LEN-1:0] elu_q88(input logic signed [DATA_LEN-1:0] x);
      real y;
      if (x >= 0) return x;
      y = ($exp($itor(x) / 256.0) - 1.0) * 256.0;
      return DATA_LEN'($rtoi(y));
   endfunction

   task automatic rand_din();
      for (int p = 0; p < POS_IN; p++)
         for (int c = 0; c < CH; c++)
            din[p][c] = DATA_LEN'($urandom);
   endtask

   task automatic check_q(input string tag);
      for (int k = 0; k < POS_OUT; k++)
         chk($sformatf("%s_row%0d", tag, k), qrow(k), exprow(k));
   endtask

   // Hold load high, measure edges to valid, check result and its stability
   task automatic run_frame(input string tag);
      int first;
      first = 0;
      load  = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         step();
         if (valid && first == 0) first = e;
         if (first != 0 && e >= first + 3) break;
      end
      chk({tag, "_latency"}, ROW_W'(first), ROW_W'(18));
      chk({tag, "_valid_hold"}, ROW_W'(valid), ROW_W'(1));
      check_q(tag);
   endtask

   // Drop load for one edge: valid clears, q kept
   task automatic idle_edge(input string tag);
      load = 1'b0;
      step();
      chk({tag, "_idle_valid"}, ROW_W'(valid), ROW_W'(0));
      chk({tag, "_idle_keep_row15"}, qrow(15), exprow(15));
   endtask

   initial begin
      rst_n     = 1'b0;
      load      = 1'b1;
      elu_valid = 1'b0;
      d         = '0;

      // Reset held 3 cycles with load high
      rand_din();
      pack_d();
      model();
      step(); step(); step();
      chk("rst_valid", ROW_W'(valid), ROW_W'(0));
      chk("rst_q_zero", ROW_W'(q == '0), ROW_W'(1));

      // Release reset with load still high
      rst_n = 1'b1;
      run_frame("rst_release");
      idle_edge("rst_release");

      // Basic ascending pattern
      for (int p = 0; p < POS_IN; p++)
         for (int c = 0; c < CH; c++)
            din[p][c] = DATA_LEN'(p*16 + c);
      pack_d();
      model();
      run_frame("basic");
      chk("basic_q15_c11", ROW_W'(qw(15, 11)), ROW_W'(16'h01FB));
      chk("basic_q0_c0", ROW_W'(qw(0, 0)), ROW_W'(16'h0010));
      idle_edge("basic");

      // Signed negatives
      for (int p = 0; p < POS_IN; p++)
         for (int c = 0; c < CH; c++)
            din[p][c] = (p % 2 == 0) ? 16'hFFF0 : 16'h8000;
      pack_d();
      model();
      run_frame("neg");
      chk("neg_q7_c5", ROW_W'(qw(7, 5)), ROW_W'(16'hFFF0));
      idle_edge("neg");

      for (int p = 0; p < POS_IN; p++)
         for (int c = 0; c < CH; c++)
            din[p][c] = (p % 2 == 0) ? 16'h0000 : 16'hFFFF;
      pack_d();
      model();
      run_frame("zero_vs_m1");
      chk("zero_vs_m1_q15_c11", ROW_W'(qw(15, 11)), ROW_W'(16'h0000));
      idle_edge("zero_vs_m1");

      // Ties at the extreme values
      rand_din();
      for (int c = 0; c < CH; c++) begin
         din[0][c]  = 16'h7FFF;
         din[1][c]  = 16'h7FFF;
         din[30][c] = 16'h8000;
         din[31][c] = 16'h8000;
      end
      pack_d();
      model();
      run_frame("tie");
      chk("tie_q0_c3", ROW_W'(qw(0, 3)), ROW_W'(16'h7FFF));
      chk("tie_q15_c9", ROW_W'(qw(15, 9)), ROW_W'(16'h8000));
      idle_edge("tie");

      // Abort: load high for 8 edges, then low
      oldq = expq;
      rand_din();
      pack_d();
      model();
      load = 1'b1;
      for (int e = 0; e < 8; e++) step();
      load = 1'b0;
      step();
      chk("abort_valid", ROW_W'(valid), ROW_W'(0));
      for (int k = 0; k < POS_OUT; k++)
         chk($sformatf("abort_row%0d", k), qrow(k), (k <= 6) ? exprow(k) : oldrow(k));
      step();

      // Restart with fresh data
      rand_din();
      pack_d();
      model();
      run_frame("restart");
      idle_edge("restart");

      // Reset asserted at edge 10 of a run
      rand_din();
      pack_d();
      load = 1'b1;
      for (int e = 0; e < 9; e++) step();
      rst_n = 1'b0;
      step();
      chk("midrst_valid", ROW_W'(valid), ROW_W'(0));
      chk("midrst_q_zero", ROW_W'(q == '0), ROW_W'(1));
      rst_n = 1'b1;
      load  = 1'b0;
      step();

      // Chained after an ELU stage: pool load follows elu valid
      for (int f = 0; f < 3; f++) begin
         elu_valid = 1'b0;
         load      = elu_valid;
         for (int w = 0; w < int'($urandom_range(1, 4)); w++) step();
         for (int p = 0; p < POS_IN; p++)
            for (int c = 0; c < CH; c++)
               din[p][c] = elu_q88(DATA_LEN'($urandom));
         pack_d();
         model();
         elu_valid = 1'b1;
         load      = elu_valid;
         run_frame($sformatf("chain%0d", f));
      end
      elu_valid = 1'b0;
      load      = elu_valid;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/maxpool_layer.md
Name: maxpool_layer

Overview:
- Downstream consumer of the ELU activation stage; takes its 32-position × 12-channel activation vector once that stage asserts valid.
- Performs 1-D max pooling, window 2, stride 2, per channel: 32 positions reduce to 16 positions × 12 channels.
- Time-multiplexed: one position pair (12 channel compares) per cycle through a 2-stage pipeline.
- Same level-sensitive load/valid protocol as the ELU stage, so the two chain directly (elu valid drives pool load).

Parameters:
- DATA_LEN, `data_len (16), width of one signed two's-complement activation word.
- CH, 12, channels per position, fixed to match the ELU stage lane count.
- POS_IN, 32, input positions; must be even.
- POS_OUT, POS_IN/2 (derived, 16), output positions.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- load  input  1  level start/hold; high = run or hold result, low = clear for next frame.
- d  input  POS_IN*CH*DATA_LEN  input vector; position p, channel c at bit offset (p*CH+c)*DATA_LEN. Must be stable while load is high.
- valid  output  1  registered; high when every word of q is final.
- q  output  POS_OUT*CH*DATA_LEN  pooled result, same packing; q position k = max(d position 2k, d position 2k+1) per channel.

Behaviour:
- Reset (rst_n=0 at an edge) has priority over everything. It sets: valid=0, q=0, rd_idx=0, wr_idx=0, stage-1 operand regs=0, stage-1 valid flag s1_v=0.
- Reset mid-run aborts the frame. A new run starts only when load is high at an edge after rst_n returns to 1.
- load=0, rst_n=1 at an edge:
  - clears valid, rd_idx, wr_idx and s1_v;
  - q keeps its value; it is not cleared, only overwritten by the next run.
- load=1, stage 1 (select):
  - while rd_idx < POS_OUT, registers the pair from positions 2*rd_idx and 2*rd_idx+1 (12 words each), sets s1_v=1 with tag=rd_idx, and increments rd_idx;
  - when rd_idx == POS_OUT, sets s1_v=0 and rd_idx holds.
- load=1, stage 2 (compare/write):
  - if s1_v, writes q position tag with the per-channel signed max of the registered pair, then increments wr_idx.
  - Ties give the shared value.
  - Compare is full-width signed; no saturation or width growth.
- Completion: when wr_idx reaches POS_OUT, valid goes to 1 on the following edge and stays 1 while load stays high. q is frozen while valid=1.
- Latency, counting the first edge with load=1 as edge 1:
  - edge 1: pair 0 selected;
  - edge 2: q position 0 written;
  - edge 17: q position 15 written;
  - edge 18: valid=1.
- load dropping mid-run aborts the run: partial q contents remain and valid stays 0. Raising load again restarts from pair 0.
- rd_idx and wr_idx are 5 bits (0..16) and never wrap. Further load-high cycles after completion change nothing.
- d changing while load=1 is a protocol violation; the result is undefined but must not hang the FSM.
- States (derived from the counters):
  - IDLE: load low.
  - FILL: rd_idx < 16.
  - DRAIN: rd_idx == 16, wr_idx < 16.
  - DONE: valid = 1.

Decomposition:
- `data_len and the CH/POS constants stay in the shared numeric header that all layer stages include. No new typedefs.
- One sub-module, max2_signed: a combinational signed max of two DATA_LEN words.
  - 12 instances are generated in stage 2.
  - It is reused by later pooling variants.
- Counters, FSM and packing logic live in maxpool_layer.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with load=1 → valid=0, q all zero. Release rst_n with load still high → valid rises exactly 18 edges later.
- Basic max: position p, channel c = p*16+c (positive) → q position k, channel c = (2k+1)*16+c. Position 15, channel 11 = 0x01FB. valid rises at edge 18.
- Signed negatives: every even position = 0xFFF0 (−16), every odd position = 0x8000 (−32768) → all q words = 0xFFF0. A further run with even = 0x0000, odd = 0xFFFF → all q words = 0x0000.
- Tie/boundary: both members equal 0x7FFF in pair 0 and 0x8000 in pair 15 → q position 0 = 0x7FFF, q position 15 = 0x8000.
- Abort and restart:
  - drop load at edge 8 → valid stays 0, q positions 0..6 hold new values;
  - raise load with new d → full correct q, valid at edge 18 of the new run.
  - Reset asserted at edge 10 of a run → valid=0 and q=0 next edge.
- Chained with the ELU stage: pool load = elu valid → pool valid follows elu valid by 18 cycles. q matches the reference model of ELU followed by max-pool over 3 random frames.
